// File: rtl/router_pkg.sv
// Shared router definitions: header field layout, packet limits and the reader FSM state type.
package router_pkg;

  localparam int unsigned HDR_LEN_MSB = 7;
  localparam int unsigned HDR_LEN_LSB = 2;
  localparam int unsigned HDR_ADDR_W  = 2;
  localparam int unsigned PKT_MAX_LEN = 63;
  localparam int unsigned LEN_W       = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  typedef enum logic [1:0] {StIdle, StHdrW, StBody, StCheck} rd_state_e;

  typedef struct packed {
    logic       sof;
    logic       eof;
    logic [7:0] data;
  } beat_t;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] hdr);
    return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

  function automatic logic [HDR_ADDR_W-1:0] hdr_addr(input logic [7:0] hdr);
    return hdr[HDR_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/router_pkt_reader_if.sv
// FIFO read port plus downstream payload stream of one router output channel.
interface router_pkt_reader_if;

  logic       valid_out;
  logic [7:0] data_out;
  logic       read_enb;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_sof;
  logic       pkt_eof;
  logic       pkt_ready;

  modport master (
    input  valid_out, data_out, pkt_ready,
    output read_enb, pkt_data, pkt_valid, pkt_sof, pkt_eof
  );

  modport slave (
    output valid_out, data_out, pkt_ready,
    input  read_enb, pkt_data, pkt_valid, pkt_sof, pkt_eof
  );

endinterface

// File: rtl/router_skid_buf.sv
// Two-entry payload buffer between the FIFO read path and the sink; head entry is held
// stable until the sink accepts it.
module router_skid_buf
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  beat_t      in_beat,
  output logic       out_valid,
  input  logic       out_ready,
  output beat_t      out_beat,
  output logic [1:0] count
);

  beat_t      mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       push;
  logic       pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_beat  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_beat;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/router_pkt_reader.sv
// Drains packets from one router output FIFO: parses the header, streams payload to the
// sink through a skid buffer and checks the trailing parity byte.
module router_pkt_reader
  import router_pkg::*;
#(
  parameter logic [HDR_ADDR_W-1:0] PORT_ADDR = 2'd0,
  parameter int unsigned           ERRCNT_W  = 8
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                soft_reset,
  router_pkt_reader_if.master bus,
  output logic                pkt_done,
  output logic [LEN_W-1:0]    pkt_len,
  output logic                parity_err,
  output logic                addr_err,
  output logic                pkt_abort,
  output logic [ERRCNT_W-1:0] err_count
);

  rd_state_e           state_q, state_d;
  logic                rd_pend_q;
  logic                armed_q;
  logic [LEN_W:0]      rem_issue_q, rem_issue_d;
  logic [LEN_W:0]      rem_rx_q, rem_rx_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [7:0]          parity_q, parity_d;
  logic                perr_q, perr_d;
  logic                aerr_q, aerr_d;
  logic                abort_q;
  logic [ERRCNT_W-1:0] err_cnt_q;

  logic       credit;
  logic       issue_ok;
  logic       done;
  logic       skid_push;
  logic       skid_in_ready;
  beat_t      skid_in;
  beat_t      skid_out;
  logic       skid_out_valid;
  logic [1:0] skid_count;

  // A returning read may need a slot, so reserve one for every read still in flight.
  assign credit   = ((skid_count + {1'b0, rd_pend_q}) <= 2'd1);
  assign issue_ok = armed_q && !soft_reset && bus.valid_out && credit;

  always_comb begin
    state_d      = state_q;
    rem_issue_d  = rem_issue_q;
    rem_rx_d     = rem_rx_q;
    len_d        = len_q;
    parity_d     = parity_q;
    perr_d       = perr_q;
    aerr_d       = aerr_q;
    bus.read_enb = 1'b0;
    skid_push    = 1'b0;
    skid_in      = '0;
    done         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (issue_ok) begin
          bus.read_enb = 1'b1;
          state_d      = StHdrW;
        end
      end
      StHdrW: begin
        if (rd_pend_q) begin
          len_d       = hdr_len(bus.data_out);
          rem_issue_d = {1'b0, len_d} + 7'd1;
          rem_rx_d    = {1'b0, len_d} + 7'd1;
          parity_d    = bus.data_out;
          aerr_d      = (hdr_addr(bus.data_out) != PORT_ADDR);
          state_d     = StBody;
        end
      end
      StBody: begin
        if (issue_ok && (rem_issue_q != '0)) begin
          bus.read_enb = 1'b1;
          rem_issue_d  = rem_issue_q - 7'd1;
        end
        if (rd_pend_q) begin
          rem_rx_d = rem_rx_q - 7'd1;
          if (rem_rx_q == 7'd1) begin
            // Parity byte: XOR over everything including it must be zero.
            perr_d  = ((parity_q ^ bus.data_out) != 8'd0);
            state_d = StCheck;
          end else begin
            parity_d     = parity_q ^ bus.data_out;
            skid_push    = 1'b1;
            skid_in.sof  = (rem_rx_q == ({1'b0, len_q} + 7'd1));
            skid_in.eof  = (rem_rx_q == 7'd2);
            skid_in.data = bus.data_out;
          end
        end
      end
      StCheck: begin
        if (skid_count == 2'd0) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (soft_reset) begin
      state_d   = StIdle;
      skid_push = 1'b0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      rd_pend_q   <= 1'b0;
      armed_q     <= 1'b0;
      rem_issue_q <= '0;
      rem_rx_q    <= '0;
      len_q       <= '0;
      parity_q    <= 8'd0;
      perr_q      <= 1'b0;
      aerr_q      <= 1'b0;
      abort_q     <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= bus.read_enb && bus.valid_out;
      armed_q     <= 1'b1;
      rem_issue_q <= rem_issue_d;
      rem_rx_q    <= rem_rx_d;
      len_q       <= len_d;
      parity_q    <= parity_d;
      perr_q      <= perr_d;
      aerr_q      <= aerr_d;
      abort_q     <= soft_reset && (state_q != StIdle);
      if (done && (perr_q || aerr_q) && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + {{(ERRCNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  router_skid_buf u_skid (
    .clock     (clock),
    .resetn    (resetn),
    .flush     (soft_reset),
    .in_valid  (skid_push),
    .in_ready  (skid_in_ready),
    .in_beat   (skid_in),
    .out_valid (skid_out_valid),
    .out_ready (bus.pkt_ready),
    .out_beat  (skid_out),
    .count     (skid_count)
  );

  // The credit rule must make overflow impossible.
  assert property (@(posedge clock) disable iff (!resetn) skid_push |-> skid_in_ready);

  assign bus.pkt_valid = skid_out_valid;
  assign bus.pkt_data  = skid_out.data;
  assign bus.pkt_sof   = skid_out.sof;
  assign bus.pkt_eof   = skid_out.eof;

  assign pkt_done   = done;
  assign pkt_len    = len_q;
  assign parity_err = done && perr_q;
  assign addr_err   = done && aerr_q;
  assign pkt_abort  = abort_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_router_pkt_reader.sv
// Bench: FIFO source model plus sink, with expected beats and completions built from packet lists.
module tb_router_pkt_reader;
  import router_pkg::*;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       soft_reset = 1'b0;
  logic       pkt_done;
  logic [5:0] pkt_len;
  logic       parity_err;
  logic       addr_err;
  logic       pkt_abort;
  logic [7:0] err_count;

  router_pkt_reader_if bus ();

  router_pkt_reader #(
    .PORT_ADDR (2'd0),
    .ERRCNT_W  (8)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .bus        (bus),
    .pkt_done   (pkt_done),
    .pkt_len    (pkt_len),
    .parity_err (parity_err),
    .addr_err   (addr_err),
    .pkt_abort  (pkt_abort),
    .err_count  (err_count)
  );

  always #5 clock = ~clock;

  logic [29:0] all_outs;
  assign all_outs = {bus.read_enb, bus.pkt_valid, bus.pkt_data, bus.pkt_sof, bus.pkt_eof,
                     pkt_done, pkt_len, parity_err, addr_err, pkt_abort, err_count};

  int         tests = 0;
  int         fails = 0;
  logic [7:0] fq[$];
  bit         fk[$];
  logic [9:0] exp_beat[$];
  logic [7:0] exp_done[$];
  logic [7:0] pay[64];
  int         model_err = 0;
  int         occ = 0;
  int         n_reads = 0;
  int         n_beats = 0;
  int         ready_mode = 0;
  bit         src_stall = 1'b0;
  bit         gap_en = 1'b0;
  int         gap_checks = 0;

  // Expected stream and completion derived directly from the packet contents.
  task automatic push_pkt(input int len, input logic [1:0] addr, input bit force_par,
                          input logic [7:0] par_in);
    logic [5:0] l6;
    logic [7:0] hdr, x, par;
    l6  = len[5:0];
    hdr = {l6, addr};
    x   = hdr;
    fq.push_back(hdr);
    fk.push_back(1'b0);
    for (int i = 0; i < len; i++) begin
      fq.push_back(pay[i]);
      fk.push_back(1'b1);
      exp_beat.push_back({(i == 0), (i == len - 1), pay[i]});
      x = x ^ pay[i];
    end
    par = force_par ? par_in : x;
    fq.push_back(par);
    fk.push_back(1'b0);
    exp_done.push_back({l6, ((x ^ par) != 8'd0), (addr != 2'd0)});
  endtask

  task automatic flush_model();
    fq.delete();
    fk.delete();
    exp_beat.delete();
    exp_done.delete();
    occ = 0;
  endtask

  task automatic wait_drain(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clock);
      if (exp_done.size() == 0 && exp_beat.size() == 0 && fq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clock);
    #2;
  endtask

  // Source FIFO, sink and monitor: sample at negedge, drive just after posedge.
  initial begin : drv
    logic       rd_fire;
    bit         prev_hold;
    bit         prev_done;
    logic [9:0] held, got, e;
    logic [7:0] d;
    bus.valid_out = 1'b0;
    bus.data_out  = 8'd0;
    bus.pkt_ready = 1'b1;
    prev_hold     = 1'b0;
    prev_done     = 1'b0;
    held          = '0;
    forever begin
      @(negedge clock);
      rd_fire = 1'b0;
      if (resetn) begin
        rd_fire = bus.read_enb && bus.valid_out;
        got     = {bus.pkt_sof, bus.pkt_eof, bus.pkt_data};
        if (rd_fire) begin
          n_reads++;
          tests++;
          if (occ > 1) begin
            fails++;
            $display("FAIL credit: %0d payload bytes held or in flight at read, required <= 1",
                     occ);
          end
        end
        if (prev_hold) begin
          tests++;
          if (!bus.pkt_valid || got !== held) begin
            fails++;
            $display("FAIL sink_hold: valid=%0b beat=%h, required valid=1 beat=%h",
                     bus.pkt_valid, got, held);
          end
        end
        if (prev_done && gap_en && bus.valid_out) begin
          gap_checks++;
          tests++;
          if (bus.read_enb !== 1'b1) begin
            fails++;
            $display("FAIL b2b_gap: read_enb=%0b after pkt_done, required 1", bus.read_enb);
          end
        end
        if (bus.pkt_valid && bus.pkt_ready) begin
          n_beats++;
          occ--;
          if (!soft_reset) begin
            tests++;
            if (exp_beat.size() == 0) begin
              fails++;
              $display("FAIL beat: got %h, required no beat", got);
            end else begin
              e = exp_beat.pop_front();
              if (got !== e) begin
                fails++;
                $display("FAIL beat: got {sof,eof,data}=%h, required %h", got, e);
              end
            end
          end
        end
        if (pkt_done) begin
          tests++;
          if (exp_done.size() == 0) begin
            fails++;
            $display("FAIL done: unexpected pkt_done");
          end else begin
            d = exp_done.pop_front();
            if ({pkt_len, parity_err, addr_err} !== d) begin
              fails++;
              $display("FAIL done: {len,perr,aerr}=%h, required %h",
                       {pkt_len, parity_err, addr_err}, d);
            end
            tests++;
            if (err_count !== model_err[7:0]) begin
              fails++;
              $display("FAIL err_count: got %0d, required %0d", err_count, model_err);
            end
            if ((d[1] || d[0]) && model_err < 255) model_err++;
          end
        end
        prev_hold = bus.pkt_valid && !bus.pkt_ready && !soft_reset;
        held      = got;
        prev_done = pkt_done;
      end else begin
        prev_hold = 1'b0;
        prev_done = 1'b0;
      end
      @(posedge clock);
      #1;
      if (rd_fire) begin
        tests++;
        if (fq.size() == 0) begin
          fails++;
          $display("FAIL source: read with empty FIFO, required none");
        end else begin
          bus.data_out = fq.pop_front();
          if (fk.pop_front()) occ++;
        end
      end else begin
        bus.data_out = 8'($urandom());
      end
      bus.valid_out = (fq.size() != 0) && !src_stall;
      case (ready_mode)
        0:       bus.pkt_ready = 1'b1;
        1:       bus.pkt_ready = ~bus.pkt_ready;
        default: bus.pkt_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic test_reset();
    #12;
    tests++;
    if (all_outs !== '0) begin
      fails++;
      $display("FAIL reset_outs: got %h, required 0", all_outs);
    end
    @(posedge clock);
    #3 resetn = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    tests++;
    if (all_outs !== '0) begin
      fails++;
      $display("FAIL idle_outs: got %h, required 0", all_outs);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int b0;
    b0 = n_beats;
    ready_mode = 0;
    pay[0] = 8'h11;
    pay[1] = 8'h22;
    pay[2] = 8'h33;
    push_pkt(3, 2'd0, 1'b1, 8'h0C);
    wait_drain(200, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_drain: timeout, required completion"); end
    tests++;
    if (n_beats - b0 != 3) begin
      fails++;
      $display("FAIL basic_beats: got %0d, required 3", n_beats - b0);
    end
    tests++;
    if (pkt_len !== 6'd3) begin
      fails++;
      $display("FAIL basic_len: got %0d, required 3", pkt_len);
    end
  endtask

  task automatic test_parity_err();
    bit ok;
    push_pkt(3, 2'd0, 1'b1, 8'h00);
    wait_drain(200, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL perr_drain: timeout, required completion"); end
    tests++;
    if (err_count !== 8'd1) begin
      fails++;
      $display("FAIL perr_count: got %0d, required 1", err_count);
    end
  endtask

  task automatic test_addr_err();
    bit ok;
    int b0;
    b0 = n_beats;
    push_pkt(0, 2'd1, 1'b1, 8'h01);
    wait_drain(200, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL aerr_drain: timeout, required completion"); end
    tests++;
    if (n_beats != b0) begin
      fails++;
      $display("FAIL len0_beats: got %0d, required 0", n_beats - b0);
    end
    tests++;
    if (err_count !== 8'd2 || pkt_len !== 6'd0) begin
      fails++;
      $display("FAIL aerr_state: err_count=%0d len=%0d, required 2 and 0", err_count, pkt_len);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int r0;
    for (int i = 0; i < 10; i++) pay[i] = 8'($urandom());
    ready_mode = 1;
    r0 = n_reads;
    push_pkt(10, 2'd0, 1'b0, 8'h00);
    repeat (6) @(posedge clock);
    #2 src_stall = 1'b1;
    repeat (3) @(posedge clock);
    #2 src_stall = 1'b0;
    wait_drain(500, ok);
    ready_mode = 0;
    tests++;
    if (!ok) begin fails++; $display("FAIL bp_drain: timeout, required completion"); end
    tests++;
    if (n_reads - r0 != 12) begin
      fails++;
      $display("FAIL bp_reads: got %0d, required 12", n_reads - r0);
    end
  endtask

  task automatic test_soft_reset();
    bit ok;
    bit hit;
    int b0;
    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom());
    ready_mode = 1;
    b0 = n_beats;
    hit = 1'b0;
    push_pkt(8, 2'd0, 1'b0, 8'h00);
    for (int i = 0; i < 500; i++) begin
      @(posedge clock);
      #2;
      if (n_beats >= b0 + 4) begin hit = 1'b1; break; end
    end
    tests++;
    if (!hit) begin fails++; $display("FAIL sr_progress: fewer than 4 beats, required 4"); end
    soft_reset = 1'b1;
    flush_model();
    @(posedge clock);
    #2 soft_reset = 1'b0;
    tests++;
    if (pkt_abort !== 1'b1 || bus.pkt_valid !== 1'b0) begin
      fails++;
      $display("FAIL sr_abort: abort=%0b valid=%0b, required 1 and 0", pkt_abort, bus.pkt_valid);
    end
    @(posedge clock);
    #2;
    tests++;
    if (pkt_abort !== 1'b0 || err_count !== model_err[7:0]) begin
      fails++;
      $display("FAIL sr_after: abort=%0b err_count=%0d, required 0 and %0d",
               pkt_abort, err_count, model_err);
    end
    ready_mode = 0;
    for (int i = 0; i < 5; i++) pay[i] = 8'($urandom());
    push_pkt(5, 2'd0, 1'b0, 8'h00);
    wait_drain(300, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL sr_next: timeout, required completion"); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int i = 0; i < 20; i++) pay[i] = 8'($urandom());
    ready_mode = 2;
    push_pkt(20, 2'd0, 1'b0, 8'h00);
    repeat (8) @(posedge clock);
    #3 resetn = 1'b0;
    #1;
    tests++;
    if (all_outs !== '0) begin
      fails++;
      $display("FAIL async_reset: outputs %h, required 0", all_outs);
    end
    flush_model();
    model_err = 0;
    ready_mode = 0;
    repeat (2) @(posedge clock);
    #3 resetn = 1'b1;
    gap_checks = 0;
    gap_en = 1'b1;
    for (int i = 0; i < 5; i++) pay[i] = 8'($urandom());
    push_pkt(5, 2'd0, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) pay[i] = 8'($urandom());
    push_pkt(7, 2'd0, 1'b0, 8'h00);
    wait_drain(400, ok);
    gap_en = 1'b0;
    tests++;
    if (!ok) begin fails++; $display("FAIL b2b_drain: timeout, required completion"); end
    tests++;
    if (gap_checks != 1) begin
      fails++;
      $display("FAIL b2b_seen: %0d header-after-done checks, required 1", gap_checks);
    end
  endtask

  task automatic test_random();
    bit ok;
    int len;
    logic [1:0] a;
    for (int p = 0; p < 6; p++) begin
      ready_mode = $urandom_range(0, 2);
      for (int k = 0; k < 2; k++) begin
        len = $urandom_range(0, PKT_MAX_LEN);
        a   = 2'($urandom_range(0, 3));
        for (int i = 0; i < len; i++) pay[i] = 8'($urandom());
        push_pkt(len, a, ($urandom_range(0, 3) == 0), 8'($urandom()));
      end
      for (int i = 0; i < 60; i++) begin
        @(posedge clock);
        #2 src_stall = ($urandom_range(0, 4) == 0);
      end
      src_stall = 1'b0;
      wait_drain(3000, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL rand_drain: batch %0d timeout", p); end
    end
    tests++;
    if (err_count !== model_err[7:0]) begin
      fails++;
      $display("FAIL rand_errcnt: got %0d, required %0d", err_count, model_err);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_addr_err();
    test_backpressure();
    test_soft_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
